// File: rtl/rr_decode_arbiter_pkg.sv
// rtl/rr_decode_arbiter_pkg.sv - shared constants, state type and round-robin pick helper
// Purpose : common definitions for the four-requester round-robin arbiter.
// Contents: NUM_REQ, DEFAULT_MAX_HOLD, ST_* state codes, state_e, rr_pick().
package rr_decode_arbiter_pkg;

    localparam int NUM_REQ          = 4;
    localparam int DEFAULT_MAX_HOLD = 16;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_GRANT   = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    typedef enum logic [1:0] {
        STATE_IDLE    = ST_IDLE,
        STATE_GRANT   = ST_GRANT,
        STATE_RELEASE = ST_RELEASE
    } state_e;

    // First set request scanning last+1, last+2, last+3, last+4 (mod 4).
    // Scanning from the far end down lets the nearest candidate win last,
    // so the previous owner is only picked when it is the sole requester.
    function automatic logic [1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                           input logic [1:0]         last);
        logic [1:0] pick;
        logic [1:0] idx;
        pick = last;
        for (int k = NUM_REQ; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx]) begin
                pick = idx;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/rr_decode_arbiter_if.sv
// rtl/rr_decode_arbiter_if.sv - request/grant bundle between requesters and the arbiter
// Purpose : groups the arbiter handshake signals.
// Signals : req[3:0], done (requester side); grant[3:0], grant_id[1:0], busy, timeout (arbiter side).
// Modports: master = requester side, slave = arbiter side.
interface rr_decode_arbiter_if;
    import rr_decode_arbiter_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic               done;
    logic [NUM_REQ-1:0] grant;
    logic [1:0]         grant_id;
    logic               busy;
    logic               timeout;

    modport master (
        output req,
        output done,
        input  grant,
        input  grant_id,
        input  busy,
        input  timeout
    );

    modport slave (
        input  req,
        input  done,
        output grant,
        output grant_id,
        output busy,
        output timeout
    );

endinterface

// File: rtl/rr_decode_arbiter_dec.sv
// rtl/rr_decode_arbiter_dec.sv - 2-to-4 one-hot decoder with enable
// Purpose: Y is the one-hot decode of W when En is high, otherwise all zero.
// Ports  : W[1:0] in, En in, Y[3:0] out.
module two_four_decoder (
    input  logic [1:0] W,
    input  logic       En,
    output logic [3:0] Y
);

    always_comb begin
        Y = 4'b0000;
        if (En) begin
            Y[W] = 1'b1;
        end
    end

endmodule

// File: rtl/rr_decode_arbiter.sv
// rtl/rr_decode_arbiter.sv - four-requester round-robin arbiter with hold timeout and dead cycle
// Purpose: grants one of four requesters in round-robin order, holds the grant until
//          done, request drop or MAX_HOLD cycles, then inserts one dead cycle.
// Ports  : clk, rst_n (async active-low), bus (slave modport: req, done in;
//          grant, grant_id, busy, timeout out).
module rr_decode_arbiter
    import rr_decode_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = DEFAULT_MAX_HOLD,
    parameter int CNT_W    = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    rr_decode_arbiter_if.slave   bus
);

    state_e           state_q,    state_d;
    logic [1:0]       grant_id_q, grant_id_d;
    logic [1:0]       last_id_q,  last_id_d;
    logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
    logic             timeout_q,  timeout_d;

    logic             rel_done;
    logic             rel_drop;
    logic             rel_hold;
    logic [3:0]       grant_w;

    // Release causes while in GRANT; the hold limit fires on the last
    // allowed cycle so the owner sees at most MAX_HOLD grant cycles.
    assign rel_done = bus.done;
    assign rel_drop = ~bus.req[grant_id_q];
    assign rel_hold = (MAX_HOLD != 0) && (hold_cnt_q == CNT_W'(MAX_HOLD - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= STATE_IDLE;
            grant_id_q <= 2'b00;
            last_id_q  <= 2'b11;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_id_q <= grant_id_d;
            last_id_q  <= last_id_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        grant_id_d = grant_id_q;
        last_id_d  = last_id_q;
        hold_cnt_d = hold_cnt_q;
        timeout_d  = 1'b0;
        case (state_q)
            STATE_IDLE: begin
                if (|bus.req) begin
                    grant_id_d = rr_pick(bus.req, last_id_q);
                    hold_cnt_d = '0;
                    state_d    = STATE_GRANT;
                end
            end
            STATE_GRANT: begin
                if (hold_cnt_q != {CNT_W{1'b1}}) begin
                    hold_cnt_d = hold_cnt_q + 1'b1;
                end
                if (rel_done || rel_drop || rel_hold) begin
                    state_d   = STATE_RELEASE;
                    last_id_d = grant_id_q;
                    // Flag a timeout only when the hold limit is the sole reason.
                    timeout_d = rel_hold && !rel_done && !rel_drop;
                end
            end
            STATE_RELEASE: begin
                state_d = STATE_IDLE;
            end
            default: begin
                state_d = STATE_IDLE;
            end
        endcase
    end

    two_four_decoder u_grant_dec (
        .W  (grant_id_q),
        .En (state_q == STATE_GRANT),
        .Y  (grant_w)
    );

    assign bus.grant    = grant_w;
    assign bus.grant_id = grant_id_q;
    assign bus.busy     = (state_q != STATE_IDLE);
    assign bus.timeout  = timeout_q;

endmodule

// File: tb/tb_rr_decode_arbiter.sv
// tb/tb_rr_decode_arbiter.sv - self-checking bench for rr_decode_arbiter
module tb_rr_decode_arbiter;

    localparam int MAXH = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    rr_decode_arbiter_if bus ();

    rr_decode_arbiter #(.MAX_HOLD(MAXH), .CNT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference: who owns the resource, how many grant cycles it has had,
    // and whether we are in the dead cycle after a release.
    int m_owner;
    int m_held;
    int m_last;
    int m_gid;
    bit m_dead;
    bit m_to;
    int grants_q[$];

    function automatic void m_reset();
        m_owner = -1;
        m_held  = 0;
        m_last  = 3;
        m_gid   = 0;
        m_dead  = 1'b0;
        m_to    = 1'b0;
    endfunction

    function automatic void m_step(input logic [3:0] r, input logic d);
        bit by_done, by_drop, by_hold;
        if (m_dead) begin
            m_dead = 1'b0;
            m_to   = 1'b0;
        end else if (m_owner >= 0) begin
            by_done = d;
            by_drop = !r[m_owner];
            by_hold = (m_held == MAXH - 1);
            if (by_done || by_drop || by_hold) begin
                m_to    = by_hold && !by_done && !by_drop;
                m_last  = m_owner;
                m_owner = -1;
                m_dead  = 1'b1;
            end else begin
                m_held++;
            end
        end else if (r != 4'b0000) begin
            for (int k = 1; k <= 4; k++) begin
                if (m_owner < 0 && r[(m_last + k) % 4]) m_owner = (m_last + k) % 4;
            end
            m_gid  = m_owner;
            m_held = 0;
            grants_q.push_back(m_owner);
        end
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [3:0] eg;
        eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
        chk({tag, " grant"},    8'(bus.grant),    8'(eg));
        chk({tag, " grant_id"}, 8'(bus.grant_id), 8'(m_gid));
        chk({tag, " busy"},     8'(bus.busy),     8'((m_owner >= 0) || m_dead));
        chk({tag, " timeout"},  8'(bus.timeout),  8'(m_dead && m_to));
    endtask

    task automatic cyc(input string tag, input logic [3:0] r, input logic d);
        bus.req  = r;
        bus.done = d;
        @(posedge clk);
        m_step(r, d);
        #1;
        check_all(tag);
    endtask

    logic [3:0] rnd_req;
    int         run_len;
    bit         to_seen;

    initial begin
        // Reset held with all requests asserted
        rst_n    = 1'b0;
        bus.req  = 4'b1111;
        bus.done = 1'b0;
        m_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all("reset");
        #3 rst_n = 1'b1;

        // First grant after reset goes to requester 0, then fairness rotation
        cyc("first", 4'b1111, 1'b0);
        chk("first grant", 8'(bus.grant), 8'h01);
        for (int i = 0; i < 30; i++) begin
            cyc("fair", 4'b1111, (m_owner >= 0 && m_held == 2));
        end
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("fair order %0d", i), 8'(grants_q[i]), 8'(i % 4));
        end
        repeat (3) cyc("drain", 4'b0000, 1'b0);

        // Single requester, done on its fourth grant cycle
        for (int i = 0; i < 8; i++) begin
            cyc("single", 4'b0001, (m_owner >= 0 && m_held == 3));
        end
        repeat (3) cyc("drain", 4'b0000, 1'b0);

        // Hold timeout with req held and no done
        run_len = 0;
        to_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            cyc("timeout", 4'b0100, 1'b0);
            if (bus.grant == 4'b0100) run_len++;
            if (bus.timeout && !to_seen) begin
                to_seen = 1'b1;
                chk("timeout hold length", 8'(run_len), 8'(MAXH));
            end
        end
        chk("timeout seen", 8'(to_seen), 8'h01);
        repeat (3) cyc("drain", 4'b0000, 1'b0);

        // done coincident with the last allowed grant cycle
        for (int i = 0; i < 20; i++) begin
            cyc("coincide", 4'b0100, (m_owner == 2 && m_held == MAXH - 1));
        end
        repeat (3) cyc("drain", 4'b0000, 1'b0);

        // Owner drops its request mid-grant
        for (int i = 0; i < 20 && !(m_owner == 2 && m_held == 5); i++) begin
            cyc("drop", 4'b0100, 1'b0);
        end
        cyc("drop", 4'b0000, 1'b0);
        chk("drop grant", 8'(bus.grant), 8'h00);
        repeat (2) cyc("drain", 4'b0000, 1'b0);

        // Randomized traffic against the model
        rnd_req = 4'b0000;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) rnd_req = 4'($urandom_range(0, 15));
            cyc("random", rnd_req, ($urandom_range(0, 7) == 0));
        end
        repeat (3) cyc("drain", 4'b0000, 1'b0);

        // Asynchronous reset while requester 1 holds the grant
        for (int i = 0; i < 10 && !(m_owner == 1 && m_held >= 1); i++) begin
            cyc("pre-reset", 4'b0010, 1'b0);
        end
        chk("pre-reset grant", 8'(bus.grant), 8'h02);
        #2 rst_n = 1'b0;
        #1;
        m_reset();
        chk("async reset grant", 8'(bus.grant), 8'h00);
        chk("async reset busy",  8'(bus.busy),  8'h00);
        chk("async reset id",    8'(bus.grant_id), 8'h00);
        @(posedge clk);
        #3 rst_n = 1'b1;
        cyc("post-reset", 4'b0011, 1'b0);
        chk("post-reset grant", 8'(bus.grant), 8'h01);
        repeat (4) cyc("post-reset", 4'b0011, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rr_decode_arbiter.md
Name: rr_decode_arbiter

Overview:
- Four-requester round-robin arbiter that shares one downstream resource. It produces a registered 2-bit grant index and a one-hot grant vector.
- The one-hot vector comes from a 2-to-4 decoder with enable, driven by the index.
- Sits between request sources (switch/FSM blocks) and the shared resource.
- Enforces fairness, an optional hold timeout, and a one-cycle dead gap between grants.

Parameters:
- MAX_HOLD, 16, maximum cycles a grant is held before forced release; 0 disables the timeout.
- CNT_W, 5, hold counter width; MAX_HOLD must be <= 2^CNT_W - 1.

Ports:
- clk  input  1  single system clock, rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req  input  4  request lines; bit i = requester i; level-sensitive.
- done  input  1  current owner finished; sampled only in GRANT.
- grant  output  4  one-hot grant; 0000 when no owner.
- grant_id  output  2  index of the current or most recent owner.
- busy  output  1  high whenever state != IDLE.
- timeout  output  1  one-cycle pulse when a grant is force-released.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset values (async, immediate on rst_n=0):
  - state=IDLE, grant=0000, grant_id=00, busy=0, timeout=0.
  - hold_cnt=0, last_id=11, so requester 0 has first priority.
- States: IDLE, GRANT, RELEASE (2-bit encoding).
- IDLE:
  - If req!=0, pick the first set bit in order last_id+1, +2, +3, +4 (mod 4). The last owner has lowest priority.
  - Register it into grant_id and go to GRANT; hold_cnt <= 0.
  - Latency: req sampled at edge N gives grant valid after edge N+1 (one cycle).
  - If req==0, stay in IDLE.
- GRANT:
  - grant = decode(grant_id) with enable=1.
  - grant is the only output that is a combinational decode of registered state; no glitch path from req.
  - hold_cnt increments each cycle, saturating at 2^CNT_W - 1.
  - Release to RELEASE on any of: done=1; req[grant_id]=0; MAX_HOLD!=0 and hold_cnt==MAX_HOLD-1.
  - Owner therefore holds at most MAX_HOLD cycles.
  - On release: last_id <= grant_id.
- RELEASE:
  - grant=0000 (decoder enable=0); grant_id keeps the last owner.
  - Lasts exactly one cycle, then IDLE. This is the mandatory dead cycle; back-to-back grants are never adjacent.
- timeout:
  - Registered; asserted only during the RELEASE cycle that follows a timeout-caused release.
- Simultaneous events:
  - done=1 in the timeout cycle: normal release, timeout stays 0.
  - req[grant_id] drop together with done: normal release.
  - New requests arriving during GRANT or RELEASE are ignored until IDLE.
  - req changes in IDLE are re-evaluated every cycle.
- Reset mid-grant: grant goes to 0000 asynchronously and the pointer returns to last_id=11.
- done outside GRANT has no effect.

Decomposition:
- Shared `include header holds:
  - state localparams ST_IDLE=2'd0, ST_GRANT=2'd1, ST_RELEASE=2'd2;
  - NUM_REQ=4;
  - default MAX_HOLD.
- One sub-module: the team's existing two_four_decoder, instantiated as u_grant_dec.
  - W=grant_id, En=(state==ST_GRANT), Y=grant.
- Priority selection, pointer and counter stay in the top module.

Test Plan:
- Reset: hold rst_n=0 with req=1111 -> grant=0000, grant_id=00, busy=0, timeout=0. After release, first grant is 0001.
- Single request: req=0001 from cycle 0, done=1 in cycle 4 -> grant=0001 in cycles 1-4, 0000 in cycle 5 (busy=1), IDLE in cycle 6 (busy=0).
- Fairness: req=1111 held, done pulsed 3 cycles into each grant -> grant sequence 0001, 0010, 0100, 1000, 0001, with exactly one 0000 cycle between grants.
- Timeout: MAX_HOLD=16, req=0100 held, done=0 -> grant=0100 for exactly 16 cycles, then 0000 with timeout=1 for one cycle, then regrant 0100 after IDLE.
- Coincident: done=1 on the 16th grant cycle -> release, timeout=0. Separately, drop req[2] mid-grant -> grant=0000 next cycle.
- Async reset mid-grant: rst_n low between clock edges while grant=0010 -> grant=0000 immediately; after rst_n release with req=0011 -> grant=0001.
